// File: rtl/arbiter_round_robin_held.sv
// Round-robin arbiter with grant hold and an optional hold-time limit that forces
// rotation. The grant is registered and presented both as a binary index and as a one-hot vector.
module arbiter_round_robin_held #(
  parameter int REQUESTER_COUNT  = 4,
  parameter int BINARY_WIDTH     = 2,
  parameter int MAX_HOLD_CYCLES  = 0,
  parameter int HOLD_COUNT_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [REQUESTER_COUNT-1:0] requests,
  output logic [REQUESTER_COUNT-1:0] grant_one_hot,
  output logic [BINARY_WIDTH-1:0]    grant_binary,
  output logic                       grant_valid,
  output logic                       grant_changed
);

  localparam logic [0:0] STATE_IDLE    = 1'b0;
  localparam logic [0:0] STATE_GRANTED = 1'b1;
  localparam logic [HOLD_COUNT_WIDTH-1:0] HOLD_LAST =
    HOLD_COUNT_WIDTH'((MAX_HOLD_CYCLES > 0) ? MAX_HOLD_CYCLES - 1 : 0);
  localparam logic [BINARY_WIDTH-1:0] LAST_INDEX = BINARY_WIDTH'(REQUESTER_COUNT - 1);

  logic [0:0]                  state, nxt_state;
  logic [BINARY_WIDTH-1:0]     ptr, nxt_ptr;
  logic [BINARY_WIDTH-1:0]     nxt_binary;
  logic                        nxt_valid, nxt_changed;
  logic [HOLD_COUNT_WIDTH-1:0] hold_count, nxt_hold_count;

  logic [BINARY_WIDTH-1:0]     grant_next;
  logic [REQUESTER_COUNT-1:0]  others;
  logic                        own_req, forced;
  logic [BINARY_WIDTH:0]       pick_idle, pick_other;

  // First set bit of mask at or above start, wrapping modulo REQUESTER_COUNT.
  // Result is {found, index}.
  function automatic logic [BINARY_WIDTH:0] pick(
    input logic [REQUESTER_COUNT-1:0] mask,
    input logic [BINARY_WIDTH-1:0]    start
  );
    logic                    found;
    logic [BINARY_WIDTH-1:0] win;
    int                      idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < REQUESTER_COUNT; k++) begin
      idx = int'(start) + k;
      if (idx >= REQUESTER_COUNT) idx = idx - REQUESTER_COUNT;
      if (!found && mask[idx]) begin
        found = 1'b1;
        win   = BINARY_WIDTH'(idx);
      end
    end
    return {found, win};
  endfunction

  // One-hot is decoded from the registered index, so no request path reaches it.
  for (genvar i = 0; i < REQUESTER_COUNT; i++) begin : g_onehot
    assign grant_one_hot[i] = grant_valid && (grant_binary == BINARY_WIDTH'(i));
  end

  always_comb begin
    grant_next = (grant_binary == LAST_INDEX) ? '0 : grant_binary + 1'b1;
    others     = requests & ~grant_one_hot;
    own_req    = |(requests & grant_one_hot);
    forced     = (MAX_HOLD_CYCLES != 0) && (hold_count == HOLD_LAST) && (|others);
    pick_idle  = pick(requests, ptr);
    pick_other = pick(others, grant_next);
  end

  always_comb begin
    nxt_state      = state;
    nxt_ptr        = ptr;
    nxt_binary     = grant_binary;
    nxt_valid      = grant_valid;
    nxt_changed    = 1'b0;
    nxt_hold_count = hold_count;
    if (state == STATE_IDLE) begin
      if (pick_idle[BINARY_WIDTH]) begin
        nxt_state      = STATE_GRANTED;
        nxt_binary     = pick_idle[BINARY_WIDTH-1:0];
        nxt_valid      = 1'b1;
        nxt_changed    = 1'b1;
        nxt_hold_count = '0;
      end
    end else if (!own_req || forced) begin
      // Release or forced rotation: the current holder never wins its own scan.
      nxt_ptr        = grant_next;
      nxt_hold_count = '0;
      if (pick_other[BINARY_WIDTH]) begin
        nxt_binary  = pick_other[BINARY_WIDTH-1:0];
        nxt_valid   = 1'b1;
        nxt_changed = 1'b1;
      end else begin
        nxt_state  = STATE_IDLE;
        nxt_binary = '0;
        nxt_valid  = 1'b0;
      end
    end else if (hold_count != '1) begin
      nxt_hold_count = hold_count + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state         <= STATE_IDLE;
      ptr           <= '0;
      grant_binary  <= '0;
      grant_valid   <= 1'b0;
      grant_changed <= 1'b0;
      hold_count    <= '0;
    end else begin
      state         <= nxt_state;
      ptr           <= nxt_ptr;
      grant_binary  <= nxt_binary;
      grant_valid   <= nxt_valid;
      grant_changed <= nxt_changed;
      hold_count    <= nxt_hold_count;
    end
  end

endmodule

// File: tb/tb_arbiter_round_robin_held.sv
// Drives one unlimited-hold arbiter and one MAX_HOLD_CYCLES=3 arbiter with shared directed
// vectors; expected grants are queued at issue time and checked by a separate monitor.
module tb_arbiter_round_robin_held;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] requests = 4'b0000;

  logic [3:0] a_oh, b_oh;
  logic [1:0] a_bin, b_bin;
  logic       a_vld, b_vld, a_chg, b_chg;

  typedef struct {
    int         id;
    logic       av;
    logic [1:0] ab;
    logic       ac;
    logic       bv;
    logic [1:0] bb;
    logic       bc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  always #5 clk = ~clk;

  arbiter_round_robin_held #(
    .REQUESTER_COUNT(4), .BINARY_WIDTH(2), .MAX_HOLD_CYCLES(0), .HOLD_COUNT_WIDTH(8)
  ) dut_a (
    .clock(clk), .clear(clear), .requests(requests),
    .grant_one_hot(a_oh), .grant_binary(a_bin), .grant_valid(a_vld), .grant_changed(a_chg)
  );

  arbiter_round_robin_held #(
    .REQUESTER_COUNT(4), .BINARY_WIDTH(2), .MAX_HOLD_CYCLES(3), .HOLD_COUNT_WIDTH(8)
  ) dut_b (
    .clock(clk), .clear(clear), .requests(requests),
    .grant_one_hot(b_oh), .grant_binary(b_bin), .grant_valid(b_vld), .grant_changed(b_chg)
  );

  task automatic compare(input string name, input int id,
                         input logic [3:0] oh, input logic [1:0] bin, input logic vld, input logic chg,
                         input logic ev, input logic [1:0] eb, input logic ec);
    logic [3:0] one;
    logic [3:0] eoh;
    one = 4'b0001;
    eoh = ev ? (one << eb) : 4'b0000;
    checks++;
    if (vld !== ev || bin !== (ev ? eb : 2'd0) || oh !== eoh || chg !== ec) begin
      errors++;
      $display("FAIL %s vec%0d: got valid=%b bin=%0d onehot=%b changed=%b, need valid=%b bin=%0d onehot=%b changed=%b",
               name, id, vld, bin, oh, chg, ev, ev ? eb : 2'd0, eoh, ec);
    end
  endtask

  // Outputs are registered and present every cycle, so every edge with a queued expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("unlimited", e.id, a_oh, a_bin, a_vld, a_chg, e.av, e.ab, e.ac);
        compare("hold3", e.id, b_oh, b_bin, b_vld, b_chg, e.bv, e.bb, e.bc);
      end
    end
  end

  task automatic step(input logic clr, input logic [3:0] req,
                      input logic av, input logic [1:0] ab, input logic ac,
                      input logic bv, input logic [1:0] bb, input logic bc);
    exp_t e;
    @(negedge clk);
    clear    = clr;
    requests = req;
    e.id = vec_id; e.av = av; e.ab = ab; e.ac = ac; e.bv = bv; e.bb = bb; e.bc = bc;
    exp_q.push_back(e);
    vec_id++;
  endtask

  task automatic both(input logic clr, input logic [3:0] req,
                      input logic v, input logic [1:0] b, input logic c);
    step(clr, req, v, b, c, v, b, c);
  endtask

  initial begin
    // reset with all requests high, then release
    both(1, 4'b1111, 0, 0, 0);
    both(1, 4'b1111, 0, 0, 0);
    both(0, 4'b1111, 1, 0, 1);
    // rotation 0,1,2,3,0 with each grantee dropping after two cycles
    both(0, 4'b1111, 1, 0, 0);
    both(0, 4'b1110, 1, 1, 1);
    both(0, 4'b1111, 1, 1, 0);
    both(0, 4'b1101, 1, 2, 1);
    both(0, 4'b1111, 1, 2, 0);
    both(0, 4'b1011, 1, 3, 1);
    both(0, 4'b1111, 1, 3, 0);
    both(0, 4'b0111, 1, 0, 1);
    // wrap and skip
    both(0, 4'b1000, 1, 3, 1);
    both(0, 4'b0101, 1, 0, 1);
    both(0, 4'b0101, 1, 0, 0);
    both(0, 4'b0100, 1, 2, 1);
    both(0, 4'b0000, 0, 0, 0);
    both(0, 4'b0000, 0, 0, 0);
    // single requester 2 for five cycles, then idle; pointer 3 wraps to 0
    both(0, 4'b0100, 1, 2, 1);
    repeat (4) both(0, 4'b0100, 1, 2, 0);
    both(0, 4'b0000, 0, 0, 0);
    both(0, 4'b0001, 1, 0, 1);
    both(0, 4'b0000, 0, 0, 0);
    // forced rotation on the hold-limited instance only
    both(1, 4'b0000, 0, 0, 0);
    step(0, 4'b0011, 1, 0, 1, 1, 0, 1);
    step(0, 4'b0011, 1, 0, 0, 1, 0, 0);
    step(0, 4'b0011, 1, 0, 0, 1, 0, 0);
    step(0, 4'b0011, 1, 0, 0, 1, 1, 1);
    step(0, 4'b0011, 1, 0, 0, 1, 1, 0);
    step(0, 4'b0011, 1, 0, 0, 1, 1, 0);
    step(0, 4'b0011, 1, 0, 0, 1, 0, 1);
    step(0, 4'b0011, 1, 0, 0, 1, 0, 0);
    step(0, 4'b0011, 1, 0, 0, 1, 0, 0);
    step(0, 4'b0011, 1, 0, 0, 1, 1, 1);
    // lone requester is never forced off
    step(0, 4'b0001, 1, 0, 0, 1, 0, 1);
    repeat (6) both(0, 4'b0001, 1, 0, 0);
    both(0, 4'b0000, 0, 0, 0);
    // mid-grant clear
    both(0, 4'b0010, 1, 1, 1);
    both(0, 4'b0010, 1, 1, 0);
    both(1, 4'b0010, 0, 0, 0);
    both(0, 4'b0010, 1, 1, 1);
    // clear returns the pointer to 0: pointer 2 would pick 3, reset pointer picks 0
    both(0, 4'b0000, 0, 0, 0);
    both(0, 4'b1001, 1, 3, 1);
    both(1, 4'b1001, 0, 0, 0);
    both(0, 4'b1001, 1, 0, 1);
    both(0, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter_round_robin_held.md
Name: arbiter_round_robin_held

Overview:
Round-robin arbiter sharing one resource among REQUESTER_COUNT requesters. Grant is held while the granted requester keeps its request high, with an optional hold-time limit. Produces the grant both as a binary index, for steering a binary-select mux, and as a one-hot vector, for per-requester enables. Sits in front of shared datapaths such as a memory port, bus master slot or mux select.

Parameters:
REQUESTER_COUNT, 4, number of requesters; must be >= 2.
BINARY_WIDTH, 2, width of the binary grant index; must satisfy 2**BINARY_WIDTH >= REQUESTER_COUNT.
MAX_HOLD_CYCLES, 0, maximum consecutive grant cycles before forced rotation when others are waiting; 0 means unlimited.
HOLD_COUNT_WIDTH, 8, width of the hold counter; must hold MAX_HOLD_CYCLES.

Ports:
clock  input  1  single clock; all logic on rising edge.
clear  input  1  synchronous, active-high reset.
requests  input  REQUESTER_COUNT  request vector; bit i high means requester i wants the resource.
grant_one_hot  output  REQUESTER_COUNT  registered one-hot grant; all-zero when idle.
grant_binary  output  BINARY_WIDTH  registered index of the current grant; 0 when idle.
grant_valid  output  1  high when any grant is active.
grant_changed  output  1  one-cycle pulse on the first cycle of each new grant.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `clear` is synchronous and active-high. On `clear`: grant_one_hot=0, grant_binary=0, grant_valid=0, grant_changed=0, hold counter=0, priority pointer=0 (requester 0 highest), state=IDLE.
- `clear` mid-grant: grant drops the following cycle. No grant is issued on the cycle `clear` is sampled high, regardless of `requests`.
- States: IDLE, GRANTED.
- IDLE:
  - If requests==0, stay in IDLE.
  - Otherwise pick the first set request scanning upward from the pointer with wrap-around. Register it into grant_binary/grant_one_hot, set grant_valid=1 and grant_changed=1, go to GRANTED.
  - Latency: request in cycle N, grant visible in cycle N+1.
- GRANTED, current grant g:
  - Release: requests[g] sampled low. Choose the next winner from the remaining requests, scanning from g+1 with wrap. Pointer becomes g+1.
    - If a winner exists, grant it the next cycle (no bubble) and pulse grant_changed.
    - If none, go to IDLE and drop grant_valid the next cycle.
  - Hold: requests[g] high, and either MAX_HOLD_CYCLES==0, or the hold counter < MAX_HOLD_CYCLES-1, or no other request is set. Keep g, increment the counter, saturating at its maximum.
  - Forced rotation: requests[g] high, MAX_HOLD_CYCLES!=0, counter == MAX_HOLD_CYCLES-1, and any other request is set. Grant the next other requester from g+1 with wrap. Requester g is excluded from that scan.
  - The counter resets to 0 on every new grant.
- Invariants:
  - grant_one_hot is always zero or exactly one bit set.
  - grant_one_hot bit grant_binary equals grant_valid.
  - grant_one_hot is derived from the registered grant_binary; a grant index >= REQUESTER_COUNT is impossible.
- Pointer wrap: g+1 == REQUESTER_COUNT wraps to 0. Arithmetic is modulo REQUESTER_COUNT, not 2**BINARY_WIDTH.
- Simultaneous release and new request in the same cycle: the new request participates in the same cycle's scan.
- Fairness bound: with MAX_HOLD_CYCLES=M>0 and all requesters continuously requesting, every requester is granted within (REQUESTER_COUNT-1)*M cycles of asserting.
- Requests are sampled only at the clock edge; no combinational path from requests to any output.

Test Plan:
- Reset and idle: assert clear with requests=4'b1111 -> all outputs 0 that cycle and the next. Deassert clear -> grant_binary=0, grant_one_hot=4'b0001, grant_changed=1 one cycle later.
- Rotation: requests=4'b1111 held, each grantee drops its request for one cycle after 2 cycles of grant -> grant sequence 0,1,2,3,0 with no idle cycle between grants; grant_changed pulses at each change.
- Wrap and skip: grant on 3, requests become 4'b0101 as 3 releases -> next grant 0 (wraps, skips 1). When 0 releases -> grant 2.
- Forced rotation: MAX_HOLD_CYCLES=3, requests=4'b0011 held -> grant 0 for 3 cycles, then 1 for 3 cycles, then 0, repeating. Same test with requests=4'b0001 -> grant 0 held indefinitely.
- Release to idle: single requester 2 asserts for 5 cycles then drops -> grant_valid high cycles N+1..N+5, low from N+6. Next request from 0 -> granted because pointer=3 wraps to 0.
- Mid-grant clear: grant active on 1, assert clear for one cycle -> next cycle grant_valid=0, pointer back to 0. With requests=4'b0010 still high -> re-grant 1 two cycles after the clear edge.
